// File: rtl/mult_pkg.sv
// Shared definitions for the sequential sign-magnitude multiplier: FSM states,
// 7-segment constants and the hex-to-segment table.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Segment encoding is active-high {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_MINUS = 7'b1000000;

   // Entry 0 is the rightmost element of the concatenation.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational decode of one hex nibble to active-high {g,f,e,d,c,b,a} segments.
module hex_to_7seg
   import mult_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seq_sm_multiplier.sv
// Sequential shift-add multiplier for sign-magnitude operands (one step per cycle).
// Define SM_MULT_DISPLAY_EN to add the 7-segment display and sign_display ports.
module seq_sm_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int NDIGITS = (2*WIDTH+3)/4
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [2*WIDTH+1:0]     operands,
   output logic                   busy,
   output logic                   done,
   output logic                   sign,
   output logic [2*WIDTH-1:0]     product
`ifdef SM_MULT_DISPLAY_EN
   ,
   output logic [7*NDIGITS-1:0]   display,
   output logic [6:0]             sign_display
`endif
);

   localparam int CW = $clog2(WIDTH+1);

   state_t             state;
   logic [2*WIDTH:0]   acc;
   logic [2*WIDTH:0]   acc_step;
   logic [WIDTH:0]     upper_sum;
   logic [WIDTH-1:0]   mcand;
   logic [CW-1:0]      cnt;
   logic               sign_r;

   logic               l_sign;
   logic               r_sign;
   logic [WIDTH-1:0]   l_mag;
   logic [WIDTH-1:0]   r_mag;

   assign l_sign = operands[2*WIDTH+1];
   assign l_mag  = operands[2*WIDTH:WIDTH+1];
   assign r_sign = operands[WIDTH];
   assign r_mag  = operands[WIDTH-1:0];

   // One shift-add step: the upper half is WIDTH+1 bits so the add carry is kept.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      upper_sum = acc[2*WIDTH:WIDTH];
      if (acc[0]) upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
      acc_step = {1'b0, upper_sum, acc[WIDTH-1:1]};
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         sign    <= 1'b0;
         product <= '0;
         acc     <= '0;
         mcand   <= '0;
         cnt     <= '0;
         sign_r  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Upper half cleared; the multiplier rides in the lower half and shifts out.
                  mcand  <= l_mag;
                  acc    <= {{(WIDTH+1){1'b0}}, r_mag};
                  sign_r <= l_sign ^ r_sign;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc <= acc_step;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH-1)) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  product <= acc_step[2*WIDTH-1:0];
                  sign    <= sign_r & (|acc_step[2*WIDTH-1:0]);
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SM_MULT_DISPLAY_EN
   logic [4*NDIGITS-1:0] nibbles;

   // Reset blanks the digits to '0' even before the registers have been cleared.
   assign nibbles      = reset ? '0 : (4*NDIGITS)'(product);
   assign sign_display = (sign && !reset) ? SEG_MINUS : SEG_BLANK;

   for (genvar d = 0; d < NDIGITS; d++) begin : g_digit
      hex_to_7seg u_hex (
         .hex (nibbles[4*d +: 4]),
         .seg (display[7*d +: 7])
      );
   end
`endif

endmodule

// File: tb/tb_seq_sm_multiplier.sv
// Self-checking bench for seq_sm_multiplier (WIDTH=4 and WIDTH=8 instances);
// display checks are active when SM_MULT_DISPLAY_EN is defined.
module tb_seq_sm_multiplier;

   localparam int W  = 4;
   localparam int W8 = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, start, start8;
   logic [2*W+1:0]    operands;
   logic [2*W8+1:0]   operands8;
   logic              busy, done, sign;
   logic [2*W-1:0]    product;
   logic              busy8, done8, sign8;
   logic [2*W8-1:0]   product8;
`ifdef SM_MULT_DISPLAY_EN
   logic [13:0]       display;
   logic [6:0]        sign_display;
   logic [27:0]       display8;
   logic [6:0]        sign_display8;
`endif

   seq_sm_multiplier #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .operands(operands),
      .busy(busy), .done(done), .sign(sign), .product(product)
`ifdef SM_MULT_DISPLAY_EN
      , .display(display), .sign_display(sign_display)
`endif
   );

   seq_sm_multiplier #(.WIDTH(W8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .operands(operands8),
      .busy(busy8), .done(done8), .sign(sign8), .product(product8)
`ifdef SM_MULT_DISPLAY_EN
      , .display(display8), .sign_display(sign_display8)
`endif
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [6:0] seg7(input logic [3:0] h);
      case (h)
         4'h0: seg7 = 7'b0111111;  4'h1: seg7 = 7'b0000110;
         4'h2: seg7 = 7'b1011011;  4'h3: seg7 = 7'b1001111;
         4'h4: seg7 = 7'b1100110;  4'h5: seg7 = 7'b1101101;
         4'h6: seg7 = 7'b1111101;  4'h7: seg7 = 7'b0000111;
         4'h8: seg7 = 7'b1111111;  4'h9: seg7 = 7'b1101111;
         4'hA: seg7 = 7'b1110111;  4'hB: seg7 = 7'b1111100;
         4'hC: seg7 = 7'b0111001;  4'hD: seg7 = 7'b1011110;
         4'hE: seg7 = 7'b1111001;  default: seg7 = 7'b1110001;
      endcase
   endfunction

   // Transaction-level model of the WIDTH=4 instance: an accepted operation
   // occupies WIDTH+2 cycles and its result appears WIDTH edges after accept.
   int         cyc = 0;
   int         accept_ok = 0;
   int         result_edge = -1;
   bit         armed = 1'b0;
   logic [7:0] pm;
   logic       ps;
   logic       exp_done, exp_busy, exp_sign;
   logic [7:0] exp_prod;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         armed       = 1'b1;
         result_edge = -1;
         accept_ok   = cyc + 1;
         exp_done    = 1'b0;
         exp_busy    = 1'b0;
         exp_prod    = '0;
         exp_sign    = 1'b0;
      end else begin
         exp_done = (cyc == result_edge);
         if (exp_done) begin
            exp_prod = pm;
            exp_sign = ps;
         end
         if (cyc >= accept_ok && start) begin
            pm          = 8'(int'(operands[8:5]) * int'(operands[3:0]));
            ps          = (operands[9] ^ operands[4]) && (pm != 0);
            result_edge = cyc + W;
            accept_ok   = cyc + W + 2;
         end
         exp_busy = (result_edge >= 0) && (cyc <= result_edge);
      end
   end

   always @(posedge clk) begin
      #1;
      if (armed) begin
         check("done", {31'b0, done}, {31'b0, exp_done});
         check("busy", {31'b0, busy}, {31'b0, exp_busy});
         check("product", {24'b0, product}, {24'b0, exp_prod});
         check("sign", {31'b0, sign}, {31'b0, exp_sign});
`ifdef SM_MULT_DISPLAY_EN
         if (reset) begin
            check("display", {18'b0, display}, {18'b0, seg7(4'h0), seg7(4'h0)});
            check("sign_display", {25'b0, sign_display}, 32'h0);
         end else begin
            check("display", {18'b0, display}, {18'b0, seg7(exp_prod[7:4]), seg7(exp_prod[3:0])});
            check("sign_display", {25'b0, sign_display}, exp_sign ? 32'h40 : 32'h0);
         end
`endif
      end
   end

   // Start one operation on the WIDTH=4 instance and check against literals.
   // The reported latency is the edge (counted from the accept edge) that samples done high.
   task automatic run_op(input string name, input logic [9:0] ops,
                         input logic [7:0] want_prod, input logic want_sign);
      int k;
      @(negedge clk);
      operands = ops;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({name, "_latency"}, k + 1, W + 1);
      check({name, "_prod"}, {24'b0, product}, {24'b0, want_prod});
      check({name, "_sign"}, {31'b0, sign}, {31'b0, want_sign});
      @(negedge clk);
      check({name, "_idle"}, {31'b0, busy}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int          done_at[$];
   logic [7:0]  prods[$];
   logic [17:0] vec8  [2];
   logic [15:0] want8 [2];
   logic        wsgn8 [2];

   initial begin
      reset = 1'b1; start = 1'b0; start8 = 1'b0;
      operands = '0; operands8 = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_sign", {31'b0, sign}, 32'h0);
      check("rst_product", {24'b0, product}, 32'h0);
      check("rst_busy8", {31'b0, busy8}, 32'h0);
      check("rst_product8", {16'b0, product8}, 32'h0);

      run_op("m3x5",   10'b1_0011_0_0101, 8'h0F, 1'b1);
      run_op("m15xm15", 10'b1_1111_1_1111, 8'hE1, 1'b0);
`ifdef SM_MULT_DISPLAY_EN
      check("disp_E1", {18'b0, display}, {18'b0, 7'b1111001, 7'b0000110});
      check("sdisp_E1", {25'b0, sign_display}, 32'h0);
`endif
      run_op("m0x7",   10'b1_0000_0_0111, 8'h00, 1'b0);
      run_op("m15x1",  10'b0_1111_1_0001, 8'h0F, 1'b1);

      // Abort: reset sampled on the edge that ends the second RUN cycle.
      @(negedge clk);
      operands = 10'b0_1111_0_1111;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'h0);
      check("abort_done", {31'b0, done}, 32'h0);
      check("abort_product", {24'b0, product}, 32'h0);
      begin
         int seen = 0;
         repeat (8) begin
            @(negedge clk);
            if (done) seen++;
         end
         check("abort_no_done", seen, 0);
      end
      run_op("after_abort", 10'b0_0110_1_0111, 8'h2A, 1'b1);

      // Reset and start together: the start is dropped.
      @(negedge clk);
      operands = 10'b0_0011_0_0011;
      start    = 1'b1;
      reset    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      check("rst_vs_start_busy", {31'b0, busy}, 32'h0);

      // Start held high; operands change while busy.
      @(negedge clk);
      operands = 10'b0_0010_0_0011;
      start    = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            done_at.push_back(cyc);
            prods.push_back(product);
         end
         if (i == 3) operands = 10'b1_0100_0_0101;
         if (i == 9) operands = 10'b1_1111_1_1111;
      end
      start = 1'b0;
      check("held_count", done_at.size(), 3);
      if (done_at.size() >= 3) begin
         check("held_gap1", done_at[1] - done_at[0], W + 2);
         check("held_gap2", done_at[2] - done_at[1], W + 2);
         check("held_prod0", {24'b0, prods[0]}, 32'h06);
         check("held_prod1", {24'b0, prods[1]}, 32'h14);
         check("held_prod2", {24'b0, prods[2]}, 32'hE1);
      end
      repeat (10) @(negedge clk);

      // WIDTH=8 instance.
      vec8[0] = {1'b0, 8'hFF, 1'b0, 8'hFF};  want8[0] = 16'hFE01; wsgn8[0] = 1'b0;
      vec8[1] = {1'b1, 8'd12, 1'b0, 8'd34};  want8[1] = 16'h0198; wsgn8[1] = 1'b1;
      for (int v = 0; v < 2; v++) begin
         int k;
         @(negedge clk);
         operands8 = vec8[v];
         start8    = 1'b1;
         @(negedge clk);
         start8 = 1'b0;
         k = 0;
         while (!done8 && k < 30) begin
            @(negedge clk);
            k++;
         end
         check($sformatf("w8_%0d_latency", v), k + 1, W8 + 1);
         check($sformatf("w8_%0d_prod", v), {16'b0, product8}, {16'b0, want8[v]});
         check($sformatf("w8_%0d_sign", v), {31'b0, sign8}, {31'b0, wsgn8[v]});
`ifdef SM_MULT_DISPLAY_EN
         if (v == 0) begin
            check("w8_display", {4'b0, display8},
                  {4'b0, 7'b1110001, 7'b1111001, 7'b0111111, 7'b0000110});
            check("w8_sign_display", {25'b0, sign_display8}, 32'h0);
         end
`endif
         repeat (2) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_sm_multiplier.md
SEQ_SM_MULTIPLIER -- requirements
Module: seq_sm_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 4: magnitude bits per operand, legal range 2..16.
REQ-002 SHALL have parameter NDIGITS, default (2*WIDTH+3)/4: number of hex display digits.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to multiply; sampled only in IDLE.
REQ-006 SHALL have port operands, input, 2*WIDTH+2: left operand in the upper WIDTH+1 bits, right operand in the lower WIDTH+1 bits; each operand is sign-magnitude with its sign in its MSB.
REQ-007 SHALL have port busy, output, 1: high while in RUN or DONE.
REQ-008 SHALL have port done, output, 1: single-cycle pulse when the result is valid.
REQ-009 SHALL have port sign, output, 1: sign of the registered product.
REQ-010 SHALL have port product, output, 2*WIDTH: registered magnitude of the product.
REQ-011 SHALL have port display, output, 7*NDIGITS, present only with the macro (REQ-026): 7-segment codes for the product nibbles, digit 0 in the LSBs.
REQ-012 SHALL have port sign_display, output, 7, present only with the macro: 7-segment code for the sign.

Function
REQ-013 SHALL implement a three-state FSM: IDLE -> RUN on start; RUN -> DONE after exactly WIDTH iterations; DONE -> IDLE unconditionally after one cycle.
REQ-014 SHALL, on the cycle start is accepted in IDLE, capture both magnitudes, compute sign as XOR of the operand signs, and clear the accumulator and iteration counter.
REQ-015 SHALL, in each RUN cycle, perform one shift-add step: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half; then shift right by one.
REQ-016 SHALL assert done for exactly one cycle in DONE, which is WIDTH+1 cycles after the start-accept edge, and SHALL update product and sign in that same cycle.
REQ-017 SHALL hold product and sign stable from done until the DONE cycle of the next accepted operation.
REQ-018 SHALL ignore start while busy, with no effect on the operation in progress.
REQ-019 SHALL accept a start that is held high continuously on every IDLE cycle, giving back-to-back operations every WIDTH+2 cycles.
REQ-020 SHALL force sign to 0 whenever the product magnitude is 0, so negative zero is never output.
REQ-021 SHALL never lose bits: the maximum magnitude (2^WIDTH-1)^2 fits in 2*WIDTH bits, and no overflow output exists.

Reset
REQ-022 SHALL, on reset high at a clock edge, enter IDLE and clear busy, done, sign, product, accumulator and counter, whatever the current state.
REQ-023 SHALL treat reset asserted mid-RUN as an abort: the partial result is discarded and done does not pulse.
REQ-024 SHALL give reset priority over a simultaneous start; that start is dropped.
REQ-025 SHALL drive display as all-'0' digit codes and sign_display as 7'b0000000 (blank) while in reset.

Configuration
REQ-026 SHALL use macro SM_MULT_DISPLAY_EN; when defined, the display and sign_display ports exist.
REQ-027 SHALL, with the macro defined, decode each product nibble combinationally to active-high segments {g,f,e,d,c,b,a}, and drive sign_display to 7'b1000000 (segment g) when sign=1 and 7'b0000000 otherwise.
REQ-028 SHALL, when the macro is undefined, omit both ports and all decode logic, with identical arithmetic and timing.

Structure
REQ-029 SHALL keep the FSM state enum (IDLE, RUN, DONE), the SEG_BLANK and SEG_MINUS constants, and the hex-to-segment table in shared package mult_pkg.
REQ-030 SHALL instantiate sub-module hex_to_7seg (4-bit in, 7-bit out) NDIGITS times, only under the macro.
REQ-031 SHALL keep the datapath as one accumulator of 2*WIDTH+1 bits, one WIDTH-bit multiplicand register, and a counter of clog2(WIDTH+1) bits.

Verification
REQ-032 SHALL test this case: WIDTH=4, operands={1_0011,0_0101} (-3 x 5), start pulsed -> done on the 5th edge after accept, sign=1, product=8'h0F.
REQ-033 SHALL test this case: {1_1111,1_1111} (-15 x -15) -> sign=0, product=8'hE1; with the macro, display={'E','1'} segments and sign_display=7'b0000000.
REQ-034 SHALL test this case: {1_0000,0_0111} (-0 x 7) -> product=0, sign=0 (negative zero suppressed).
REQ-035 SHALL test this case: reset asserted on the 2nd RUN cycle -> IDLE next edge, product=0, no done pulse; a new start then completes normally.
REQ-036 SHALL test this case: start held high, with operands changed while busy -> results reflect only operands captured at each accept, and done pulses every 6 cycles.
REQ-037 SHALL test this case: WIDTH=8, {0_11111111,0_11111111} -> product=16'hFE01 after 9 cycles.
